rom_fetch_sequencer: RTL and testbench
======================================

// Module: rom_fetch_sequencer
// PURPOSE
//  Sequences the 16x8 program ROM: drives its address, captures each 8-bit word into an
//  instruction register and offers it downstream on a valid/ready handshake. Runs from
//  address 0 to LAST_ADDR, supports redirects (jumps) and faults on out-of-range
//  addresses. Sits between the ROM and the K2 execute/decode stage.
// PARAMETERS
//  AW         4   ROM address width
//  DW         8   ROM data width
//  LAST_ADDR  8   highest populated ROM address; reaching it ends the program
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   synchronous, active-low reset
//  start        in   1   pulse: begin program at address 0
//  abort        in   1   pulse: stop immediately and return to IDLE
//  rom_addr     out  AW  address to ROM; ROM is combinational (same-cycle data)
//  rom_data     in   DW  ROM read data
//  instr        out  DW  captured instruction word
//  instr_valid  out  1   instr holds a valid word
//  instr_ready  in   1   consumer accepts instr this cycle
//  jump_en      in   1   with accept: redirect next fetch to jump_target
//  jump_target  in   AW  redirect address
//  pc           out  AW  address of the word currently in instr
//  busy         out  1   high in FETCH or HOLD
//  done         out  1   high in DONE
//  fault        out  1   high in FAULT
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, pc=0, rom_addr=0, instr=0, all flags 0.
//  - States: IDLE, FETCH, HOLD, DONE, FAULT. Encoding is a package enum.
//  - IDLE: rom_addr=0. start -> FETCH with fetch address 0.
//  - FETCH (one cycle): rom_addr=fetch address; instr<=rom_data, pc<=fetch address,
//    instr_valid<=1, -> HOLD. Latency start->instr_valid = 2 cycles.
//  - HOLD: instr/pc stable while instr_valid=1 and instr_ready=0.
//    On accept (instr_valid & instr_ready):
//      next = jump_en ? jump_target : pc+1 (AW bits, wraps mod 2^AW);
//      pc==LAST_ADDR and jump_en=0 -> DONE, instr_valid<=0;
//      else next>LAST_ADDR -> FAULT, instr_valid<=0;
//      else -> FETCH at next, instr_valid<=0 (one-cycle bubble per word).
//  - A jump taken on the last word is a legal redirect and does not end the program.
//  - DONE / FAULT: sticky; rom_addr=0. start -> FETCH at 0 (clears done/fault).
//  - abort has priority over start and the accept path in every state: -> IDLE,
//    instr_valid<=0, pc unchanged. Reset has priority over abort.
//  - start is ignored in FETCH and HOLD.
//  - jump_en/jump_target are sampled only on an accept cycle.
//  - Never drive rom_addr>LAST_ADDR (unpopulated words read as X).
// STRUCTURE
//  - Package k2_rom_pkg: state enum seq_state_e, ROM_AW=4, ROM_DW=8, ROM_LAST=8.
//  - Single module: FSM, pc/next-address logic and instr register are inline.
//    Optional sub-module rom_addr_gen (next-address mux + range check).
//  - Instantiated next to ROM: ROM.a <= rom_addr, rom_data <= ROM.b.
// TESTING
//  - Reset then start, ready=1 -> instr 0x08,0x19,0x20,0x10,0x70,0x00,0x14,0x04,0xB2
//    at pc 0..8; done=1 after the 0xB2 accept; 18 cycles start->done.
//  - Back-pressure: ready=0 for 5 cycles at pc=1 -> instr stays 0x19, valid stays 1,
//    pc stays 1; next word 0x20.
//  - Jump: accept at pc=2 with jump_en=1, target=7 -> next instr 0x04 at pc=7, then
//    0xB2, then done.
//  - Fault: jump_target=12 on accept -> fault=1, instr_valid=0, rom_addr stays <=8;
//    start -> instr 0x08 at pc 0.
//  - Abort mid-HOLD at pc=4 (instr=0x70) -> IDLE next cycle, valid=0, busy=0;
//    abort+start same cycle -> IDLE.
//  - rst_n=0 during HOLD -> all outputs 0 next edge; start in HOLD is ignored.

Source files
------------

// File: rtl/k2_rom_pkg.sv
// Shared types and sizes for the K2 program-ROM fetch sequencer.
// Holds the ROM geometry and the sequencer state encoding.
package k2_rom_pkg;

    localparam int ROM_AW   = 4;
    localparam int ROM_DW   = 8;
    localparam int ROM_LAST = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } seq_state_e;

endpackage

// File: rtl/rom_addr_gen.sv
// Next-fetch address selection and range qualification
// for the program-ROM sequencer.
module rom_addr_gen #(
    parameter int AW        = 4,
    parameter int LAST_ADDR = 8
) (
    input  logic [AW-1:0] pc_i,
    input  logic          jump_en_i,
    input  logic [AW-1:0] jump_target_i,
    output logic [AW-1:0] next_o,
    output logic          last_o,
    output logic          oor_o
);

    localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

    always_comb begin
        next_o = jump_en_i ? jump_target_i : pc_i + AW'(1);
        // A taken jump on the last word is a redirect, not program end
        last_o = (pc_i == LAST) && !jump_en_i;
        oor_o  = next_o > LAST;
    end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Walks the program ROM, registers each word and offers it
// downstream on a valid/ready handshake with jump and fault support.
module rom_fetch_sequencer
    import k2_rom_pkg::*;
#(
    parameter int AW        = ROM_AW,
    parameter int DW        = ROM_DW,
    parameter int LAST_ADDR = ROM_LAST
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_target,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] faddr_q, faddr_d;
    logic [DW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;

    logic [AW-1:0] next_addr;
    logic          at_last;
    logic          out_of_range;

    rom_addr_gen #(
        .AW        (AW),
        .LAST_ADDR (LAST_ADDR)
    ) u_addr_gen (
        .pc_i          (pc_q),
        .jump_en_i     (jump_en),
        .jump_target_i (jump_target),
        .next_o        (next_addr),
        .last_o        (at_last),
        .oor_o         (out_of_range)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            faddr_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (start) begin
                        state_d = S_FETCH;
                        faddr_d = '0;
                    end
                end
                S_FETCH: begin
                    instr_d = rom_data;
                    pc_d    = faddr_q;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (valid_q && instr_ready) begin
                        valid_d = 1'b0;
                        if (at_last) begin
                            state_d = S_DONE;
                        end else if (out_of_range) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_FETCH;
                            faddr_d = next_addr;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // faddr_q is only ever loaded with an in-range address
    assign rom_addr    = (state_q == S_FETCH) ? faddr_q : '0;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_HOLD);
    assign done        = (state_q == S_DONE);
    assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench for the program-ROM fetch sequencer
// with a behavioural 16x8 ROM holding the reference program.
module tb_rom_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_en;
    logic [3:0] jump_target;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic       fault;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_word [0:8] = '{8'h08, 8'h19, 8'h20, 8'h10, 8'h70,
                                   8'h00, 8'h14, 8'h04, 8'hB2};

    rom_fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [3:0] a);
        case (a)
            4'd0: rom_f = 8'h08;
            4'd1: rom_f = 8'h19;
            4'd2: rom_f = 8'h20;
            4'd3: rom_f = 8'h10;
            4'd4: rom_f = 8'h70;
            4'd5: rom_f = 8'h00;
            4'd6: rom_f = 8'h14;
            4'd7: rom_f = 8'h04;
            4'd8: rom_f = 8'hB2;
            default: rom_f = 8'hxx;
        endcase
    endfunction

    assign rom_data = rom_f(rom_addr);

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rom_addr > 4'd8) begin
            errors++;
            $display("FAIL rom_addr_range: got %0d, need <= 8", rom_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Accepts words with ready=1 until the word at pc p is held, then drops ready
    task automatic advance_to(input logic [3:0] p, output bit ok);
        ok = 1'b0;
        instr_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (instr_valid && pc == p) begin
                ok = 1'b1;
                break;
            end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({instr, instr_valid, pc, rom_addr, busy, done, fault} !== '0) begin
            errors++;
            $display("FAIL reset: instr=%h v=%b pc=%0d ra=%0d b=%b d=%b f=%b, need all 0",
                     instr, instr_valid, pc, rom_addr, busy, done, fault);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sequence();
        int n;
        int idx;
        bit bad;
        instr_ready = 1'b1;
        pulse_start();
        n = 0;
        idx = 0;
        bad = 1'b0;
        while (!done && n < 40) begin
            step();
            n++;
            if (instr_valid) begin
                if (idx > 8 || instr !== exp_word[idx] || pc !== 4'(idx)) begin
                    bad = 1'b1;
                    $display("FAIL seq_word: idx=%0d got instr=%h pc=%0d", idx, instr, pc);
                end
                idx++;
            end
        end
        checks++;
        if (bad) errors++;
        checks++;
        if (idx != 9) begin
            errors++;
            $display("FAIL seq_count: got %0d words, need 9", idx);
        end
        checks++;
        if (n != 18 || done !== 1'b1) begin
            errors++;
            $display("FAIL seq_latency: got %0d cycles done=%b, need 18 done=1", n, done);
        end
        checks++;
        if (instr_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL done_state: v=%b busy=%b ra=%0d, need 0 0 0",
                     instr_valid, busy, rom_addr);
        end
        instr_ready = 1'b0;
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_sticky: got %b, need 1", done);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: done=%b busy=%b, need 0 1", done, busy);
        end
        advance_to(4'd1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_reach: timeout, need pc 1");
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (instr !== 8'h19 || instr_valid !== 1'b1 || pc !== 4'd1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: instr=%h v=%b pc=%0d, need 19 1 1", instr, instr_valid, pc);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        checks++;
        if (instr !== 8'h20 || pc !== 4'd2 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_next: instr=%h pc=%0d v=%b, need 20 2 1", instr, pc, instr_valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_jump();
        bit ok;
        pulse_start();
        advance_to(4'd2, ok);
        jump_en = 1'b1;
        jump_target = 4'd7;
        instr_ready = 1'b1;
        step();
        jump_en = 1'b0;
        jump_target = 4'd0;
        step();
        checks++;
        if (!ok || instr !== 8'h04 || pc !== 4'd7 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL jump_target: instr=%h pc=%0d v=%b, need 04 7 1", instr, pc, instr_valid);
        end
        step();
        step();
        checks++;
        if (instr !== 8'hB2 || pc !== 4'd8) begin
            errors++;
            $display("FAIL jump_last: instr=%h pc=%0d, need B2 8", instr, pc);
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL jump_done: got %b, need 1", done);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_last_jump();
        bit ok;
        pulse_start();
        advance_to(4'd8, ok);
        jump_en = 1'b1;
        jump_target = 4'd1;
        instr_ready = 1'b1;
        step();
        jump_en = 1'b0;
        instr_ready = 1'b0;
        step();
        checks++;
        if (!ok || done !== 1'b0 || instr !== 8'h19 || pc !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL last_jump: done=%b instr=%h pc=%0d busy=%b, need 0 19 1 1",
                     done, instr, pc, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_fault();
        bit ok;
        pulse_start();
        advance_to(4'd0, ok);
        jump_en = 1'b1;
        jump_target = 4'd12;
        instr_ready = 1'b1;
        step();
        jump_en = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if (!ok || fault !== 1'b1 || instr_valid !== 1'b0 || rom_addr > 4'd8) begin
            errors++;
            $display("FAIL fault_enter: fault=%b v=%b ra=%0d, need 1 0 <=8",
                     fault, instr_valid, rom_addr);
        end
        step();
        step();
        checks++;
        if (fault !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: fault=%b busy=%b, need 1 0", fault, busy);
        end
        pulse_start();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: got %b, need 0", fault);
        end
        step();
        checks++;
        if (instr !== 8'h08 || pc !== 4'd0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL fault_restart: instr=%h pc=%0d v=%b, need 08 0 1",
                     instr, pc, instr_valid);
        end
    endtask

    task automatic test_abort();
        bit ok;
        advance_to(4'd4, ok);
        checks++;
        if (!ok || instr !== 8'h70) begin
            errors++;
            $display("FAIL abort_pre: instr=%h, need 70", instr);
        end
        abort = 1'b1;
        instr_ready = 1'b1;
        step();
        abort = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || busy !== 1'b0 || pc !== 4'd4 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: v=%b busy=%b pc=%0d done=%b, need 0 0 4 0",
                     instr_valid, busy, pc, done);
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_start: busy=%b v=%b, need 0 0", busy, instr_valid);
        end
    endtask

    task automatic test_reset_in_hold();
        bit ok;
        pulse_start();
        advance_to(4'd3, ok);
        pulse_start();
        checks++;
        if (!ok || instr !== 8'h10 || pc !== 4'd3 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_in_hold: instr=%h pc=%0d v=%b, need 10 3 1",
                     instr, pc, instr_valid);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({instr, instr_valid, pc, rom_addr, busy, done, fault} !== '0) begin
            errors++;
            $display("FAIL reset_hold: instr=%h v=%b pc=%0d ra=%0d b=%b d=%b f=%b, need all 0",
                     instr, instr_valid, pc, rom_addr, busy, done, fault);
        end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        instr_ready = 1'b0;
        jump_en = 1'b0;
        jump_target = 4'd0;
        test_reset();
        test_sequence();
        test_backpressure();
        test_jump();
        test_last_jump();
        test_fault();
        test_abort();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
